// File: rtl/mv_conv_scheduler_pkg.sv
// Shared channel/state types, scaling constants and small helpers for the
// millivolt conversion scheduler.
package mv_sched_pkg;
    localparam int          NUM_CH     = 3;
    localparam logic [11:0] VREF_MV    = 12'd3300;
    localparam int          XADC_SHIFT = 12;
    localparam int          CODE_SHIFT = 8;

    typedef enum logic [1:0] {
        CH_XADC = 2'd0,
        CH_PWM  = 2'd1,
        CH_R2R  = 2'd2
    } ch_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_STORE = 2'd2
    } state_e;

    // XADC multiplies the full raw word; the averagers contribute only their code byte.
    function automatic logic [15:0] chan_operand(input logic [1:0] ch, input logic [15:0] hold);
        if (ch == CH_XADC) begin
            return hold;
        end
        return {8'd0, hold[15:8]};
    endfunction

    function automatic logic [15:0] chan_scale(input logic [1:0] ch, input logic [27:0] prod);
        if (ch == CH_XADC) begin
            return 16'(prod >> XADC_SHIFT);
        end
        return 16'(prod >> CODE_SHIFT);
    endfunction

    function automatic logic [1:0] onehot_to_ch(input logic [2:0] oh);
        case (oh)
            3'b010:  return CH_PWM;
            3'b100:  return CH_R2R;
            default: return CH_XADC;
        endcase
    endfunction
endpackage

// File: rtl/mv_conv_scheduler_arbiter.sv
// Combinational round-robin arbiter: searches the pending vector starting at
// the pointer and reports the winner plus the pointer that follows it.
module mv_rr_arbiter
    import mv_sched_pkg::*;
(
    input  logic [2:0] pending_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] grant_o,
    output logic       grant_valid_o,
    output logic [1:0] next_ptr_o
);
    logic [1:0] idx;

    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        next_ptr_o    = ptr_i;
        idx           = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = 2'((int'(ptr_i) + i) % NUM_CH);
            if (!grant_valid_o && pending_i[idx]) begin
                grant_o[idx]  = 1'b1;
                grant_valid_o = 1'b1;
                next_ptr_o    = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
        end
    end
endmodule

// File: rtl/mv_conv_scheduler.sv
// Shares one registered 16x12 multiplier between the XADC, PWM and R2R channels
// and returns per-channel millivolt results with one-cycle valid pulses.
module mv_conv_scheduler
    import mv_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] xadc_raw,
    input  logic        xadc_req,
    input  logic [15:0] pwm_scaled,
    input  logic        pwm_req,
    input  logic [15:0] r2r_scaled,
    input  logic        r2r_req,
    input  logic        clr_ovr,
    output logic [15:0] xadc_mv,
    output logic [15:0] pwm_mv,
    output logic [15:0] r2r_mv,
    output logic [2:0]  mv_valid,
    output logic        busy,
    output logic [2:0]  overrun
);
    state_e      state_q, state_d;
    logic [1:0]  ptr_q;
    logic [2:0]  pending_q, pending_d;
    logic [2:0]  ovr_q, ovr_d;
    logic [2:0]  valid_q, valid_d;
    logic [15:0] hold_q [NUM_CH];
    logic [15:0] mv_q   [NUM_CH];
    logic [15:0] sample [NUM_CH];
    logic [15:0] operand_q;
    logic [1:0]  chan_q;
    logic [27:0] product_q;

    logic [2:0]  req;
    logic [2:0]  arb_grant;
    logic        arb_valid;
    logic [1:0]  arb_next_ptr;
    logic [1:0]  grant_ch;
    logic [2:0]  granted;
    logic        grant_en;

    assign req       = {r2r_req, pwm_req, xadc_req};
    assign sample[0] = xadc_raw;
    assign sample[1] = pwm_scaled;
    assign sample[2] = r2r_scaled;

    mv_rr_arbiter u_arb (
        .pending_i     (pending_q),
        .ptr_i         (ptr_q),
        .grant_o       (arb_grant),
        .grant_valid_o (arb_valid),
        .next_ptr_o    (arb_next_ptr)
    );

    assign grant_ch = onehot_to_ch(arb_grant);
    assign granted  = grant_en ? arb_grant : 3'b000;

    // A strobe in the grant cycle re-arms pending; only a non-granted pending channel overruns.
    assign pending_d = (pending_q & ~granted) | req;
    assign ovr_d     = (clr_ovr ? 3'b000 : ovr_q) | (req & pending_q & ~granted);

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        valid_d  = 3'b000;
        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    grant_en = 1'b1;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                state_d = S_STORE;
            end
            S_STORE: begin
                valid_d = 3'b001 << chan_q;
                if (arb_valid) begin
                    grant_en = 1'b1;
                    state_d  = S_MUL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= CH_XADC;
            pending_q <= '0;
            ovr_q     <= '0;
            valid_q   <= '0;
            operand_q <= '0;
            chan_q    <= CH_XADC;
            product_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                hold_q[k] <= '0;
                mv_q[k]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
            valid_q   <= valid_d;
            if (grant_en) begin
                ptr_q     <= arb_next_ptr;
                chan_q    <= grant_ch;
                operand_q <= chan_operand(grant_ch, hold_q[grant_ch]);
            end
            if (state_q == S_MUL) begin
                product_q <= 28'(operand_q) * 28'(VREF_MV);
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (req[k]) begin
                    hold_q[k] <= sample[k];
                end
                if (valid_d[k]) begin
                    mv_q[k] <= chan_scale(chan_q, product_q);
                end
            end
        end
    end

    assign xadc_mv  = mv_q[0];
    assign pwm_mv   = mv_q[1];
    assign r2r_mv   = mv_q[2];
    assign mv_valid = valid_q;
    assign overrun  = ovr_q;
    assign busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_mv_conv_scheduler.sv
// Scoreboard bench for mv_conv_scheduler: expected results are queued as
// strobes are driven and matched against each mv_valid pulse.
module tb_mv_conv_scheduler;
    logic        clk = 1'b0;
    logic        resetN;
    logic [15:0] xadcRaw, pwmScaled, r2rScaled;
    logic        xadcReq, pwmReq, r2rReq, clrOvr;
    logic [15:0] xadcMv, pwmMv, r2rMv;
    logic [2:0]  mvValid, overrun;
    logic        busy;

    typedef struct {
        logic [2:0]  valid;
        logic [15:0] value;
        int          cycle;
    } exp_t;

    exp_t sbQ[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   c0;

    mv_conv_scheduler dut (
        .clk        (clk),
        .reset_n    (resetN),
        .xadc_raw   (xadcRaw),
        .xadc_req   (xadcReq),
        .pwm_scaled (pwmScaled),
        .pwm_req    (pwmReq),
        .r2r_scaled (r2rScaled),
        .r2r_req    (r2rReq),
        .clr_ovr    (clrOvr),
        .xadc_mv    (xadcMv),
        .pwm_mv     (pwmMv),
        .r2r_mv     (r2rMv),
        .mv_valid   (mvValid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [2:0] valid, input logic [15:0] value, input int cycle);
        exp_t e;
        e.valid = valid;
        e.value = value;
        e.cycle = cycle;
        sbQ.push_back(e);
    endtask

    // Drives one cycle of strobes on the selected channels, then releases them.
    task automatic applyStimulus(input logic [2:0] req, input logic [15:0] x, input logic [15:0] p, input logic [15:0] r);
        xadcRaw   = x;
        pwmScaled = p;
        r2rScaled = r;
        {r2rReq, pwmReq, xadcReq} = req;
        waitCycle();
        {r2rReq, pwmReq, xadcReq} = 3'b000;
    endtask

    task automatic resetDut();
        resetN = 1'b0;
        {r2rReq, pwmReq, xadcReq} = 3'b000;
        clrOvr = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        waitCycle();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sbQ.size() > 0; i++) waitCycle();
        if (sbQ.size() != 0) checkOutput("drain_timeout", sbQ.size(), 0);
        repeat (3) waitCycle();
    endtask

    // Scoreboard side: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] obs;
        if (resetN && mvValid != 3'b000) begin
            checkOutput("valid_onehot", $countones(mvValid), 1);
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_valid", mvValid, 0);
            end else begin
                e   = sbQ.pop_front();
                obs = (e.valid == 3'b001) ? xadcMv : (e.valid == 3'b010) ? pwmMv : r2rMv;
                checkOutput("valid_chan", mvValid, e.valid);
                checkOutput("mv_value", obs, e.value);
                checkOutput("valid_cycle", cyc, e.cycle);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetN = 1'b0;
        xadcRaw = '0; pwmScaled = '0; r2rScaled = '0;
        xadcReq = 1'b0; pwmReq = 1'b0; r2rReq = 1'b0; clrOvr = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;
        waitCycle();

        checkOutput("rst_xadc_mv", xadcMv, 0);
        checkOutput("rst_pwm_mv", pwmMv, 0);
        checkOutput("rst_r2r_mv", r2rMv, 0);
        checkOutput("rst_valid", mvValid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_overrun", overrun, 0);

        c0 = cyc;
        pushExp(3'b001, 16'd3299, c0 + 4);
        applyStimulus(3'b001, 16'd4095, 16'd0, 16'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checkOutput("latency_busy", busy, (i == 2 || i == 3) ? 1 : 0);
            waitCycle();
        end
        drain();

        resetDut();
        c0 = cyc;
        pushExp(3'b001, 16'd1650, c0 + 4);
        pushExp(3'b010, 16'd1650, c0 + 6);
        pushExp(3'b100, 16'd3287, c0 + 8);
        applyStimulus(3'b111, 16'd2048, 16'h8000, 16'hFF00);
        drain();

        resetDut();
        c0 = cyc;
        pushExp(3'b001, 16'd80, c0 + 4);
        pushExp(3'b010, 16'd206, c0 + 6);
        applyStimulus(3'b001, 16'd100, 16'd0, 16'd0);
        applyStimulus(3'b010, 16'd0, 16'h4000, 16'd0);
        applyStimulus(3'b010, 16'd0, 16'h1000, 16'd0);
        repeat (4) waitCycle();
        checkOutput("ovr_set", overrun, 3'b010);
        waitCycle();
        checkOutput("ovr_sticky", overrun, 3'b010);
        clrOvr = 1'b1;
        waitCycle();
        clrOvr = 1'b0;
        checkOutput("ovr_cleared", overrun, 3'b000);
        drain();

        resetDut();
        c0 = cyc;
        pushExp(3'b001, 16'd3222, c0 + 4);
        pushExp(3'b001, 16'd6, c0 + 6);
        applyStimulus(3'b001, 16'd4000, 16'd0, 16'd0);
        applyStimulus(3'b001, 16'd8, 16'd0, 16'd0);
        drain();
        checkOutput("ovr_same_cycle", overrun, 3'b000);

        resetDut();
        c0 = cyc;
        pushExp(3'b001, 16'd52799, c0 + 4);
        pushExp(3'b100, 16'd0, c0 + 6);
        applyStimulus(3'b101, 16'hFFFF, 16'd0, 16'h00FF);
        drain();

        resetDut();
        c0 = cyc;
        for (int i = 0; i < 9; i++) begin
            case (i % 3)
                0:       pushExp(3'b001, 16'd805, c0 + 4 + 2 * i);
                1:       pushExp(3'b010, 16'd206, c0 + 4 + 2 * i);
                default: pushExp(3'b100, 16'd412, c0 + 4 + 2 * i);
            endcase
        end
        xadcRaw = 16'd1000; pwmScaled = 16'h1000; r2rScaled = 16'h2000;
        {r2rReq, pwmReq, xadcReq} = 3'b111;
        repeat (12) waitCycle();
        {r2rReq, pwmReq, xadcReq} = 3'b000;
        drain();
        checkOutput("fair_ovr", overrun, 3'b111);
        clrOvr = 1'b1;
        waitCycle();
        clrOvr = 1'b0;
        checkOutput("fair_ovr_clr", overrun, 3'b000);

        applyStimulus(3'b001, 16'd500, 16'd0, 16'd0);
        waitCycle();
        checkOutput("mid_busy", busy, 1);
        #1 resetN = 1'b0;
        #1;
        checkOutput("mid_rst_xadc", xadcMv, 0);
        checkOutput("mid_rst_pwm", pwmMv, 0);
        checkOutput("mid_rst_r2r", r2rMv, 0);
        checkOutput("mid_rst_valid", mvValid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_ovr", overrun, 0);
        #1 resetN = 1'b1;
        repeat (8) waitCycle();
        c0 = cyc;
        pushExp(3'b001, 16'd402, c0 + 4);
        applyStimulus(3'b001, 16'd500, 16'd0, 16'd0);
        drain();

        checkOutput("sb_empty", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
